// File: rtl/soc_bus_pkg.sv
// rtl/soc_bus_pkg.sv - shared hub bus transfer type, byte-lane helper and pin port register offsets
package soc_bus_pkg;

   localparam logic [1:0] PIN_LEVEL = 2'd0;
   localparam logic [1:0] PIN_RISE  = 2'd1;
   localparam logic [1:0] PIN_FALL  = 2'd2;
   localparam logic [1:0] PIN_IRQEN = 2'd3;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic        ren;
      logic        wen;
   } bus_xfer_t;

   function automatic logic [31:0] byte_mask(input logic [3:0] wmask);
      return {{8{wmask[3]}}, {8{wmask[2]}}, {8{wmask[1]}}, {8{wmask[0]}}};
   endfunction

endpackage

// File: rtl/pin_debouncer.sv
// rtl/pin_debouncer.sv - single-bit debouncer: output follows input after CYCLES consecutive differing samples
module pin_debouncer #(
   parameter int CYCLES = 12000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic seed,
   input  logic sample,
   output logic level
);

   localparam int CW = $clog2(CYCLES + 1);

   logic [CW-1:0] count;

   // seed adopts the first real synchronised sample so pins held at reset need no debounce delay
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level <= 1'b0;
         count <= '0;
      end else if (seed) begin
         level <= sample;
         count <= '0;
      end else if (sample == level) begin
         count <= '0;
      end else if (count == CW'(CYCLES - 1)) begin
         level <= sample;
         count <= '0;
      end else begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/parallel_input.sv
// rtl/parallel_input.sv - input pin port with level, sticky W1C edge flags and maskable irq
// Optional debouncing is built when PARALLEL_INPUT_DEBOUNCE_EN is defined.
module parallel_input
   import soc_bus_pkg::*;
#(
   parameter int WIDTH           = 32,
   parameter int DEBOUNCE_CYCLES = 12000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [31:0]      addr,
   input  logic [31:0]      wdata,
   input  logic [3:0]       wmask,
   input  logic             ren,
   input  logic             wen,
   output logic [31:0]      rdata,
   output logic             ready,
   input  logic             active,
   input  logic [WIDTH-1:0] io,
   output logic             irq
);

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
   localparam int WARM = 3;
`else
   localparam int WARM = 2;
`endif

   if (WIDTH < 1 || WIDTH > 32 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
      $error("parallel_input: unsupported parameter values");
   end

   bus_xfer_t        xfer;
   logic [WIDTH-1:0] sync1, sync2, level, prev;
   logic [WIDTH-1:0] rise, fall, irq_en;
   logic [WIDTH-1:0] wr_bits, lane_bits, clr_rise, clr_fall, new_rise, new_fall, rd_value;
   logic [WARM-1:0]  warm;
   logic             primed, hit, wr_hit, unused;

   assign xfer   = {addr, wdata, wmask, ren, wen};
   assign unused = ^{xfer.addr[31:4], xfer.addr[1:0]};

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
   for (genvar i = 0; i < WIDTH; i++) begin : g_deb
      pin_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
         .clk    (clk),
         .rst_n  (rst_n),
         .seed   (warm[1] & ~warm[2]),
         .sample (sync2[i]),
         .level  (level[i])
      );
   end
`else
   assign level = sync2;
`endif

   assign hit       = active & (xfer.ren | xfer.wen);
   assign wr_hit    = active & xfer.wen;
   assign lane_bits = WIDTH'(byte_mask(xfer.wmask));
   assign wr_bits   = WIDTH'(xfer.wdata) & lane_bits;
   assign clr_rise  = (wr_hit && xfer.addr[3:2] == PIN_RISE) ? wr_bits : '0;
   assign clr_fall  = (wr_hit && xfer.addr[3:2] == PIN_FALL) ? wr_bits : '0;
   // edges only count once prev holds a real sample, so pins high out of reset do not flag
   assign new_rise  = primed ? (level & ~prev) : '0;
   assign new_fall  = primed ? (~level & prev) : '0;

   always_comb begin
      rd_value = '0;
      case (xfer.addr[3:2])
         PIN_LEVEL: rd_value = level;
         PIN_RISE:  rd_value = rise;
         PIN_FALL:  rd_value = fall;
         default:   rd_value = irq_en;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1  <= '0;
         sync2  <= '0;
         prev   <= '0;
         rise   <= '0;
         fall   <= '0;
         irq_en <= '0;
         warm   <= '0;
         primed <= 1'b0;
         ready  <= 1'b0;
         rdata  <= '0;
         irq    <= 1'b0;
      end else begin
         sync1  <= io;
         sync2  <= sync1;
         prev   <= level;
         warm   <= {warm[WARM-2:0], 1'b1};
         primed <= warm[WARM-1];
         rise   <= (rise & ~clr_rise) | new_rise;
         fall   <= (fall & ~clr_fall) | new_fall;
         if (wr_hit && xfer.addr[3:2] == PIN_IRQEN) begin
            irq_en <= (irq_en & ~lane_bits) | wr_bits;
         end
         ready  <= hit;
         rdata  <= (active && xfer.ren) ? 32'(rd_value) : '0;
         irq    <= |((rise | fall) & irq_en);
      end
   end

endmodule

// File: tb/tb_parallel_input.sv
// tb/tb_parallel_input.sv - self-checking bench for parallel_input (define PARALLEL_INPUT_DEBOUNCE_EN for the debounce build)
`timescale 1ns/1ps
module tb_parallel_input;
   import soc_bus_pkg::*;

   localparam int DB = 4;
`ifdef PARALLEL_INPUT_DEBOUNCE_EN
   localparam int FIRST_REAL = 3;
   localparam int EXTRA      = DB;
`else
   localparam int FIRST_REAL = 2;
   localparam int EXTRA      = 0;
`endif

   logic        clk, rst_n, ren, wen, ready, active, irq;
   logic [31:0] addr, wdata, rdata, io;
   logic [3:0]  wmask;

   parallel_input #(.WIDTH(32), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .wmask(wmask),
      .ren(ren), .wen(wen), .rdata(rdata), .ready(ready), .active(active),
      .io(io), .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] io_q[$];
   logic [31:0] lvl_q[$];
   logic [31:0] rise_m, fall_m, ien_m;

   typedef struct {
      string       name;
      logic [31:0] io;
      int          settle;
      logic        rd;
      logic        wr;
      logic [1:0]  r;
      logic [31:0] wdata;
      logic [3:0]  wmask;
      logic [31:0] exp;
   } vec_t;

   vec_t tbl[16];

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] lanes(logic [3:0] m);
      logic [31:0] v;
      v = '0;
      for (int i = 0; i < 4; i++) v[i*8 +: 8] = {8{m[i]}};
      return v;
   endfunction

   // synchronised pin value visible after edge m: the pins as sampled one edge earlier
   function automatic logic [31:0] s_at(int m);
      if (m < 2) return '0;
      return io_q[m-2];
   endfunction

   function automatic logic [31:0] level_at_edge(int kn);
      logic [31:0] lv, smp;
      if (kn < FIRST_REAL) return '0;
`ifdef PARALLEL_INPUT_DEBOUNCE_EN
      if (kn == FIRST_REAL) return s_at(kn - 1);
      lv = lvl_q[kn-1];
      if (kn - DB < FIRST_REAL + 1) return lv;
      for (int b = 0; b < 32; b++) begin
         bit run;
         run = 1'b1;
         for (int m = kn - DB; m < kn; m++) begin
            smp = s_at(m);
            if (smp[b] == lv[b]) run = 1'b0;
         end
         if (run) lv[b] = ~lv[b];
      end
      return lv;
`else
      smp = s_at(kn);
      lv  = smp;
      return lv;
`endif
   endfunction

   function automatic logic [31:0] reg_read(logic [1:0] a);
      case (a)
         2'd0:    return lvl_q[lvl_q.size()-1];
         2'd1:    return rise_m;
         2'd2:    return fall_m;
         default: return ien_m;
      endcase
   endfunction

   task automatic model_reset();
      io_q.delete();
      lvl_q.delete();
      lvl_q.push_back('0);
      rise_m = '0;
      fall_m = '0;
      ien_m  = '0;
   endtask

   task automatic tick();
      logic [31:0] exp_rdata, lv, nr, nf, bm;
      logic        exp_ready, exp_irq;
      int          kn;
      @(posedge clk);
      kn        = lvl_q.size();
      exp_ready = active & (ren | wen);
      exp_rdata = (active & ren) ? reg_read(addr[3:2]) : '0;
      exp_irq   = |((rise_m | fall_m) & ien_m);
      io_q.push_back(io);
      lv = level_at_edge(kn);
      nr = '0;
      nf = '0;
      if (kn >= FIRST_REAL + 2) begin
         nr = lvl_q[kn-1] & ~lvl_q[kn-2];
         nf = ~lvl_q[kn-1] & lvl_q[kn-2];
      end
      bm = lanes(wmask) & wdata;
      if (active & wen) begin
         case (addr[3:2])
            2'd1:    rise_m = rise_m & ~bm;
            2'd2:    fall_m = fall_m & ~bm;
            2'd3:    ien_m  = (ien_m & ~lanes(wmask)) | bm;
            default: ;
         endcase
      end
      rise_m = rise_m | nr;
      fall_m = fall_m | nf;
      lvl_q.push_back(lv);
      #1;
      check("ready", 32'(ready), 32'(exp_ready));
      check("rdata", rdata, exp_rdata);
      check("irq", 32'(irq), 32'(exp_irq));
   endtask

   task automatic bus(input logic rd, input logic wr, input logic [1:0] r, input logic [31:0] d,
                      input logic [3:0] m, input logic act, output logic [31:0] got, output logic got_ready);
      addr   = {28'h0, r, 2'b00};
      ren    = rd;
      wen    = wr;
      wdata  = d;
      wmask  = m;
      active = act;
      tick();
      got       = rdata;
      got_ready = ready;
      ren    = 1'b0;
      wen    = 1'b0;
      active = 1'b0;
      wdata  = '0;
      wmask  = '0;
   endtask

   task automatic do_reset(input logic [31:0] pins);
      rst_n = 1'b0;
      io    = pins;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] got;
      logic        got_ready;

      rst_n = 1'b0; ren = 1'b0; wen = 1'b0; active = 1'b0;
      addr = '0; wdata = '0; wmask = '0; io = 32'h0000_000F;
      model_reset();
      #1;
      check("reset_rdata", rdata, 32'h0);
      check("reset_ready", 32'(ready), 32'h0);
      check("reset_irq", 32'(irq), 32'h0);
      do_reset(32'h0000_000F);

      tbl[0]  = '{"level_reset",   32'hF, 3, 1, 0, PIN_LEVEL, 32'h0,        4'h0, 32'hF};
      tbl[1]  = '{"rise_primed",   32'hF, 0, 1, 0, PIN_RISE,  32'h0,        4'h0, 32'h0};
      tbl[2]  = '{"fall_primed",   32'hF, 0, 1, 0, PIN_FALL,  32'h0,        4'h0, 32'h0};
      tbl[3]  = '{"fall_bit0",     32'hE, 4, 1, 0, PIN_FALL,  32'h0,        4'h0, 32'h1};
      tbl[4]  = '{"rise_bit0",     32'hF, 4, 1, 0, PIN_RISE,  32'h0,        4'h0, 32'h1};
      tbl[5]  = '{"w1c_rise",      32'hF, 0, 0, 1, PIN_RISE,  32'h1,        4'hF, 32'h0};
      tbl[6]  = '{"rise_cleared",  32'hF, 0, 1, 0, PIN_RISE,  32'h0,        4'h0, 32'h0};
      tbl[7]  = '{"fall_kept",     32'hF, 0, 1, 0, PIN_FALL,  32'h0,        4'h0, 32'h1};
      tbl[8]  = '{"w1c_fall",      32'hF, 0, 0, 1, PIN_FALL,  32'h1,        4'hF, 32'h0};
      tbl[9]  = '{"fall_cleared",  32'hF, 0, 1, 0, PIN_FALL,  32'h0,        4'h0, 32'h0};
      tbl[10] = '{"ien_bytemask",  32'hF, 0, 0, 1, PIN_IRQEN, 32'hFFFF_FFFF, 4'h1, 32'h0};
      tbl[11] = '{"ien_read",      32'hF, 0, 1, 0, PIN_IRQEN, 32'h0,        4'h0, 32'hFF};
      tbl[12] = '{"ien_rw_same",   32'hF, 0, 1, 1, PIN_IRQEN, 32'h2,        4'hF, 32'hFF};
      tbl[13] = '{"ien_after",     32'hF, 0, 1, 0, PIN_IRQEN, 32'h0,        4'h0, 32'h2};
      tbl[14] = '{"level_wr_ign",  32'hF, 0, 0, 1, PIN_LEVEL, 32'hFFFF,     4'hF, 32'h0};
      tbl[15] = '{"level_kept",    32'hF, 0, 1, 0, PIN_LEVEL, 32'h0,        4'h0, 32'hF};

      foreach (tbl[i]) begin
         io = tbl[i].io;
         repeat (tbl[i].settle + ((tbl[i].settle > 3) ? EXTRA : 0)) tick();
         bus(tbl[i].rd, tbl[i].wr, tbl[i].r, tbl[i].wdata, tbl[i].wmask, 1'b1, got, got_ready);
         if (tbl[i].rd) check(tbl[i].name, got, tbl[i].exp);
         check({tbl[i].name, "_ack"}, 32'(got_ready), 32'h1);
      end

      // io[1] falls with IRQ_EN=0x2: flag, then irq one cycle later, then W1C drops irq one cycle after the ack
      io = 32'hD;
      repeat (3 + EXTRA) tick();
      check("irq_lags_flag", 32'(irq), 32'h0);
      tick();
      check("irq_set", 32'(irq), 32'h1);
      bus(1'b1, 1'b0, PIN_FALL, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("fall_bit1", got, 32'h2);
      bus(1'b0, 1'b1, PIN_FALL, 32'h2, 4'hF, 1'b1, got, got_ready);
      check("irq_at_w1c_ack", 32'(irq), 32'h1);
      tick();
      check("irq_cleared", 32'(irq), 32'h0);

      bus(1'b1, 1'b1, PIN_IRQEN, 32'hFFFF_FFFF, 4'hF, 1'b0, got, got_ready);
      check("inactive_no_ready", 32'(got_ready), 32'h0);
      bus(1'b1, 1'b0, PIN_IRQEN, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("inactive_no_effect", got, 32'h2);

      // io[2] rises on the same edge as a W1C of RISE bit2: the set wins
      io = 32'h9;
      repeat (4 + EXTRA) tick();
      bus(1'b0, 1'b1, PIN_FALL, 32'hFFFF_FFFF, 4'hF, 1'b1, got, got_ready);
      io = 32'hD;
      repeat (2 + EXTRA) tick();
      bus(1'b0, 1'b1, PIN_RISE, 32'h4, 4'hF, 1'b1, got, got_ready);
      bus(1'b1, 1'b0, PIN_RISE, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("set_beats_w1c", got, 32'h4);

`ifdef PARALLEL_INPUT_DEBOUNCE_EN
      io = 32'h5;
      repeat (10) tick();
      bus(1'b0, 1'b1, PIN_RISE, 32'hFFFF_FFFF, 4'hF, 1'b1, got, got_ready);
      bus(1'b0, 1'b1, PIN_FALL, 32'hFFFF_FFFF, 4'hF, 1'b1, got, got_ready);
      io = 32'hD;
      repeat (3) tick();
      io = 32'h5;
      for (int c = 0; c < 10; c++) begin
         bus(1'b1, 1'b0, PIN_LEVEL, 32'h0, 4'h0, 1'b1, got, got_ready);
         check("glitch_filtered", got, 32'h5);
      end
      bus(1'b1, 1'b0, PIN_RISE, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("glitch_no_rise", got, 32'h0);
      io = 32'hD;
      repeat (6) tick();
      io = 32'h5;
      repeat (12) tick();
      bus(1'b1, 1'b0, PIN_RISE, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("pulse_rise_bit3", got, 32'h8);
      bus(1'b1, 1'b0, PIN_FALL, 32'h0, 4'h0, 1'b1, got, got_ready);
      check("pulse_fall_bit3", got, 32'h8);
`endif

      // back-to-back strobes: ack every cycle without stall
      addr = {28'h0, PIN_IRQEN, 2'b00}; ren = 1'b1; active = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         check("b2b_ready", 32'(ready), 32'h1);
      end

      // async reset during a read drops ready at once
      addr = {28'h0, PIN_LEVEL, 2'b00};
      tick();
      check("ready_before_reset", 32'(ready), 32'h1);
      ren = 1'b0; active = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      check("ready_async_reset", 32'(ready), 32'h0);
      check("rdata_async_reset", rdata, 32'h0);
      check("irq_async_reset", 32'(irq), 32'h0);
      do_reset($urandom);

      for (int c = 0; c < 800; c++) begin
         if ($urandom_range(0, 7 + EXTRA) == 0) io = io ^ (32'h1 << $urandom_range(0, 31));
         if ($urandom_range(0, 40) == 0) io = $urandom;
         addr   = $urandom;
         wdata  = $urandom;
         wmask  = 4'($urandom_range(0, 15));
         active = ($urandom_range(0, 3) != 0);
         ren    = ($urandom_range(0, 1) != 0);
         wen    = ($urandom_range(0, 3) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
